// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a requester and the bin2bcd_seq converter.
// The requester drives start/bin; the converter returns status and the BCD result.
interface bin2bcd_seq_if #(
    parameter int DIGITS = 4,
    parameter int BITS   = 14
);
    logic                  start;
    logic [BITS-1:0]       bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcds;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcds, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcds, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Result is registered and only updated on the final iteration.
//
// state | meaning
// IDLE  | waiting for start; bcds/overflow hold the last result
// SHIFT | one add-3/shift iteration per clock, BITS iterations total
module bin2bcd_seq #(
    parameter int DIGITS = 4,
    parameter int BITS   = 14
) (
    input  logic           clk,
    input  logic           rst,
    bin2bcd_seq_if.slave   bus
);
    localparam int CW = $clog2(BITS + 1);
    localparam int WW = 4 * DIGITS;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [WW-1:0]   work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [WW-1:0]   bcds_q, bcds_d;
    logic            ovf_q, ovf_d;

    logic [WW-1:0]   work_adj;
    logic [WW-1:0]   work_next;

    // Digits are adjusted independently; no carry crosses a digit boundary.
    always_comb begin
        work_adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        work_next = {work_adj[WW-2:0], shift_q[BITS-1]};
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcds_d     = bcds_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.bin;
                    work_d     = '0;
                    cnt_d      = CW'(BITS);
                    ovf_pend_d = (64'(bus.bin) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = work_next;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcds_d  = work_next;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcds_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcds_q     <= bcds_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcds     = bcds_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with default parameters (4 digits, 14-bit input).
module tb_bin2bcd_seq;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    bin2bcd_seq_if #(.DIGITS(4), .BITS(14)) bus ();

    bin2bcd_seq #(.DIGITS(4), .BITS(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps from the current sample point until done is seen (or 40 edges pass).
    task automatic wait_done(input logic [15:0] hold, output int lat, output int busy_n,
                             output bit bad_hold, output bit both_hi);
        lat = 0; busy_n = 0; bad_hold = 0; both_hi = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done && bus.busy) both_hi = 1;
            if (bus.done) break;
            if (bus.busy) busy_n++;
            if (bus.bcds !== hold) bad_hold = 1;
        end
    endtask

    task automatic convert(input string tag, input logic [13:0] v, input logic [15:0] prev,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat, busy_n;
        bit bad_hold, both_hi;
        bus.bin = v; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        wait_done(prev, lat, busy_n, bad_hold, both_hi);
        chk({tag, "_latency"}, 32'(lat), 32'd14);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd13);
        chk({tag, "_bcds_hold"}, 32'(bad_hold), 32'd0);
        chk({tag, "_done_busy_overlap"}, 32'(both_hi), 32'd0);
        chk({tag, "_bcds"}, 32'(bus.bcds), 32'(exp_bcd));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat, busy_n, pulses, busy_seen;
        bit bad_hold, both_hi;
        n_assert = 0; n_fail = 0;
        rst = 1'b1; bus.start = 1'b0; bus.bin = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_bcds", 32'(bus.bcds), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);

        convert("zero", 14'd0, 16'h0000, 16'h0000, 1'b0);
        convert("c1234", 14'd1234, 16'h0000, 16'h1234, 1'b0);
        convert("c9999", 14'd9999, 16'h1234, 16'h9999, 1'b0);
        convert("c10000", 14'd10000, 16'h9999, 16'h0000, 1'b1);
        convert("c16383", 14'd16383, 16'h0000, 16'h6383, 1'b1);
        convert("c5", 14'd5, 16'h6383, 16'h0005, 1'b0);

        // Second start at cycle 5 while busy must be dropped.
        bus.bin = 14'd42; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.bin = 14'd77; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(16'h0005, lat, busy_n, bad_hold, both_hi);
        chk("ign_latency", 32'(lat), 32'd9);
        chk("ign_bcds", 32'(bus.bcds), 32'h0042);
        chk("ign_overflow", 32'(bus.overflow), 32'd0);
        pulses = 0; busy_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
            if (bus.busy) busy_seen++;
        end
        chk("ign_extra_done", 32'(pulses), 32'd0);
        chk("ign_extra_busy", 32'(busy_seen), 32'd0);

        // start held high: the done cycle is IDLE, so the next accept is one edge later.
        bus.bin = 14'd321; bus.start = 1'b1;
        @(posedge clk); #1;
        wait_done(16'h0042, lat, busy_n, bad_hold, both_hi);
        chk("b2b1_latency", 32'(lat), 32'd14);
        chk("b2b1_bcds", 32'(bus.bcds), 32'h0321);
        bus.bin = 14'd654;
        wait_done(16'h0321, lat, busy_n, bad_hold, both_hi);
        bus.start = 1'b0;
        chk("b2b2_done_spacing", 32'(lat), 32'd15);
        chk("b2b2_busy_between", 32'(busy_n), 32'd14);
        chk("b2b2_hold", 32'(bad_hold), 32'd0);
        chk("b2b2_overlap", 32'(both_hi), 32'd0);
        chk("b2b2_bcds", 32'(bus.bcds), 32'h0654);

        // Async reset in the middle of a conversion; prime overflow=1 first.
        convert("pre_rst", 14'd12000, 16'h0654, 16'h2000, 1'b1);
        bus.bin = 14'd8888; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_bcds", 32'(bus.bcds), 32'd0);
        chk("arst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        convert("c8888", 14'd8888, 16'h0000, 16'h8888, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
